phase_timer: RTL and testbench

PHASE_TIMER -- requirements
Module: phase_timer

---
 rtl/phase_timer.sv | 95 +++++++++
 tb/tb_phase_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Multi-channel down-counting timer sharing one prescaler, with
//               per-channel load, auto-reload or one-shot mode, and tc/zero flags.
// Revision    : 1.0
// ============================================================================
module phase_timer #(
    parameter int NBITS    = 16,
    parameter int NCH      = 4,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH*NBITS-1:0]   cnt_ini,
    input  logic [NCH-1:0]         load,
    input  logic [NCH*NBITS-1:0]   load_val,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         auto_rl,
    output logic [NCH*NBITS-1:0]   q,
    output logic [NCH-1:0]         tc,
    output logic [NCH-1:0]         zero
);

    localparam logic [NBITS-1:0] c_ONE = NBITS'(1);

    logic w_tick;

    generate
        if (PRESCALE <= 1) begin : g_psc_bypass
            assign w_tick = 1'b1;
        end else begin : g_psc
            localparam int            c_PSC_W    = $clog2(PRESCALE);
            localparam logic [c_PSC_W-1:0] c_PSC_LAST = c_PSC_W'(PRESCALE - 1);

            logic [c_PSC_W-1:0] r_psc;

            // Free-running: neither en nor load perturb the phase.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_psc <= '0;
                end else if (r_psc == c_PSC_LAST) begin
                    r_psc <= '0;
                end else begin
                    r_psc <= r_psc + c_PSC_W'(1);
                end
            end

            assign w_tick = (r_psc == c_PSC_LAST);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [NBITS-1:0] r_q;
            logic [NBITS-1:0] r_rl;
            logic             r_tc;
            logic             w_step;

            assign w_step = en[gi] & w_tick;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q  <= cnt_ini[gi*NBITS +: NBITS];
                    r_rl <= cnt_ini[gi*NBITS +: NBITS];
                    r_tc <= 1'b0;
                end else if (load[gi]) begin
                    r_q  <= load_val[gi*NBITS +: NBITS];
                    r_rl <= load_val[gi*NBITS +: NBITS];
                    r_tc <= 1'b0;
                end else if (w_step) begin
                    if (r_q > c_ONE) begin
                        r_q  <= r_q - c_ONE;
                        r_tc <= 1'b0;
                    end else if (r_q == c_ONE) begin
                        // Mode is only looked at on the terminal step.
                        r_q  <= auto_rl[gi] ? r_rl : '0;
                        r_tc <= 1'b1;
                    end else begin
                        r_tc <= 1'b0;
                    end
                end else begin
                    r_tc <= 1'b0;
                end
            end

            assign q[gi*NBITS +: NBITS] = r_q;
            assign tc[gi]               = r_tc;
            assign zero[gi]             = (r_q == '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_phase_timer.sv
`default_nettype none
// Randomized and directed checks of phase_timer (PRESCALE=1 and PRESCALE=4)
// against an arithmetic reference model of the channel rules.
module tb_phase_timer;

    localparam int NB = 16;
    localparam int NC = 4;
    localparam int PB = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC*NB-1:0]  cnt_ini;
    logic [NC*NB-1:0]  load_val;
    logic [NC-1:0]     load;
    logic [NC-1:0]     en;
    logic [NC-1:0]     auto_rl;
    logic [NC*NB-1:0]  q_a;
    logic [NC*NB-1:0]  q_b;
    logic [NC-1:0]     tc_a;
    logic [NC-1:0]     tc_b;
    logic [NC-1:0]     zero_a;
    logic [NC-1:0]     zero_b;

    int total = 0;
    int bad   = 0;

    int mq   [2][NC];
    int mrl  [2][NC];
    int mtc  [2][NC];
    int mcyc [2];
    int per  [2];
    int ncyc = 0;

    phase_timer #(.NBITS(NB), .NCH(NC), .PRESCALE(1)) u_dut_a (
        .clk(clk), .reset(reset), .cnt_ini(cnt_ini), .load(load),
        .load_val(load_val), .en(en), .auto_rl(auto_rl),
        .q(q_a), .tc(tc_a), .zero(zero_a)
    );

    phase_timer #(.NBITS(NB), .NCH(NC), .PRESCALE(PB)) u_dut_b (
        .clk(clk), .reset(reset), .cnt_ini(cnt_ini), .load(load),
        .load_val(load_val), .en(en), .auto_rl(auto_rl),
        .q(q_b), .tc(tc_b), .zero(zero_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int qa(input int ch);
        return int'(q_a[ch*NB +: NB]);
    endfunction

    function automatic int qb(input int ch);
        return int'(q_b[ch*NB +: NB]);
    endfunction

    // Reference: tick falls on the last cycle of every PRESCALE-cycle window since reset.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit tick;
            tick = ((mcyc[k] % per[k]) == per[k] - 1);
            for (int c = 0; c < NC; c++) begin
                if (reset) begin
                    mq[k][c]  = int'(cnt_ini[c*NB +: NB]);
                    mrl[k][c] = mq[k][c];
                    mtc[k][c] = 0;
                end else if (load[c]) begin
                    mq[k][c]  = int'(load_val[c*NB +: NB]);
                    mrl[k][c] = mq[k][c];
                    mtc[k][c] = 0;
                end else if (en[c] && tick && mq[k][c] == 1) begin
                    mq[k][c]  = auto_rl[c] ? mrl[k][c] : 0;
                    mtc[k][c] = 1;
                end else begin
                    if (en[c] && tick && mq[k][c] > 1) mq[k][c] = mq[k][c] - 1;
                    mtc[k][c] = 0;
                end
            end
            mcyc[k] = reset ? 0 : mcyc[k] + 1;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("a_q%0d", c),    qa(c),            mq[0][c]);
            chk($sformatf("a_tc%0d", c),   tc_a[c],          mtc[0][c]);
            chk($sformatf("a_zero%0d", c), zero_a[c],        (mq[0][c] == 0));
            chk($sformatf("b_q%0d", c),    qb(c),            mq[1][c]);
            chk($sformatf("b_tc%0d", c),   tc_b[c],          mtc[1][c]);
            chk($sformatf("b_zero%0d", c), zero_b[c],        (mq[1][c] == 0));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        ncyc++;
        #1;
        check_all();
    endtask

    initial begin
        int exp_q1[4];
        int exp_t1[4];
        int last_tc;
        int frozen;

        per[0] = 1;
        per[1] = PB;
        mcyc[0] = 0;
        mcyc[1] = 0;

        reset = 1'b1;
        load = '0; en = '0; auto_rl = '0; load_val = '0;
        for (int c = 0; c < NC; c++) cnt_ini[c*NB +: NB] = NB'($urandom_range(2, 30));
        cyc();
        cyc();
        for (int c = 0; c < NC; c++) begin
            chk("rst_q", qa(c), int'(cnt_ini[c*NB +: NB]));
            chk("rst_tc", tc_a[c], 0);
        end
        reset = 1'b0;

        // One-shot on ch0: 3,2,1,0,0 with tc on the step reaching 0.
        load[0] = 1'b1; load_val[0*NB +: NB] = 16'd3; en[0] = 1'b1;
        cyc();
        chk("os_load", qa(0), 3);
        load[0] = 1'b0;
        exp_q1 = '{2, 1, 0, 0};
        exp_t1 = '{0, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("os_q", qa(0), exp_q1[i]);
            chk("os_tc", tc_a[0], exp_t1[i]);
        end
        chk("os_zero", zero_a[0], 1);

        // Auto-reload on ch1 with rl=2; DUT b period must be 8 cycles.
        load[1] = 1'b1; load_val[1*NB +: NB] = 16'd2; auto_rl[1] = 1'b1; en[1] = 1'b1;
        cyc();
        chk("ar_load", qa(1), 2);
        load[1] = 1'b0;
        last_tc = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (i < 6) begin
                chk("ar_q", qa(1), (i % 2 == 0) ? 1 : 2);
                chk("ar_tc", tc_a[1], (i % 2 == 1) ? 1 : 0);
            end
            if (tc_b[1]) begin
                if (last_tc >= 0) chk("ar_period_b", i - last_tc, 8);
                last_tc = i;
            end
        end
        chk("ar_seen_b", (last_tc >= 24), 1);

        // Collision: load beats the terminal step.
        load[2] = 1'b1; load_val[2*NB +: NB] = 16'd2; en[2] = 1'b0;
        cyc();
        load[2] = 1'b0; en[2] = 1'b1;
        cyc();
        chk("col_q1", qa(2), 1);
        load[2] = 1'b1; load_val[2*NB +: NB] = 16'd5;
        cyc();
        chk("col_q5", qa(2), 5);
        chk("col_tc", tc_a[2], 0);
        load_val[2*NB +: NB] = 16'd1;
        cyc();
        load[2] = 1'b0;
        reset = 1'b1; load[2] = 1'b1; load_val[2*NB +: NB] = 16'd7;
        cyc();
        chk("col_rst_q", qa(2), int'(cnt_ini[2*NB +: NB]));
        chk("col_rst_tc", tc_a[2], 0);
        reset = 1'b0; load = '0;
        cyc();
        chk("col_post_tc", tc_a[2], 0);

        // Boundaries on ch3: parked at 0, then rl=1 pulses every step.
        load[3] = 1'b1; load_val[3*NB +: NB] = 16'd0; auto_rl[3] = 1'b1; en[3] = 1'b1;
        cyc();
        load[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("b0_q", qa(3), 0);
            chk("b0_tc", tc_a[3], 0);
        end
        load[3] = 1'b1; load_val[3*NB +: NB] = 16'd1;
        cyc();
        load[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("b1_q", qa(3), 1);
            chk("b1_tc", tc_a[3], 1);
        end

        // Independence and freeze of ch3.
        load = '1; auto_rl = '1; en = '1;
        load_val = {16'd10, 16'd20, 16'd30, 16'd40};
        cyc();
        load = '0; en[3] = 1'b0;
        frozen = qb(3);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("frz_a", qa(3), 10);
            chk("frz_b", qb(3), frozen);
        end
        en[3] = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NC; c++) begin
                load[c]    = ($urandom_range(0, 9) == 0);
                en[c]      = ($urandom_range(0, 9) < 8);
                auto_rl[c] = $urandom_range(0, 1);
                load_val[c*NB +: NB] = NB'($urandom_range(0, 12));
                cnt_ini[c*NB +: NB]  = NB'($urandom_range(0, 12));
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
